// File: rtl/mvm_stream_par.sv
`timescale 1ns/1ps
// mvm_stream_par: signed y = A*x with P parallel MAC lanes; A and x persist across runs.
// Results appear N*M/P cycles after start; DRAIN holds data_out stable while out_ready is low.

module mvm_stream_par #(
  parameter int M   = 8,
  parameter int N   = 8,
  parameter int B   = 8,
  parameter int P   = 2,
  parameter int SAT = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_matrix,
  input  logic                  load_vector,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [B-1:0]   data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [2*B-1:0] data_out,
  output logic                  busy,
  output logic                  done
);

  localparam int G    = M / P;
  localparam int PW   = 2 * B;
  localparam int ACCW = 2 * B + $clog2(N);
  localparam int IW   = (M * N > 1) ? $clog2(M * N) : 1;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int GW   = (G > 1) ? $clog2(G) : 1;
  localparam int KW   = (M > 1) ? $clog2(M) : 1;

  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-PW+1){1'b0}}, {(PW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = {{(ACCW-PW+1){1'b1}}, {(PW-1){1'b0}}};

  generate
    if ((M % P) != 0) begin : g_bad_p
      $error("mvm_stream_par: M must be a multiple of P");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_X, COMPUTE, DRAIN} state_t;

  state_t state, state_nx;

  logic [IW-1:0] idx;
  logic [CW-1:0] col;
  logic [GW-1:0] grp;
  logic [KW-1:0] k;

  logic signed [B-1:0]    a_mem [M*N];
  logic signed [B-1:0]    x_mem [N];
  logic signed [PW-1:0]   y_mem [M];
  logic signed [ACCW-1:0] acc    [P];
  logic signed [ACCW-1:0] acc_nx [P];
  logic signed [PW-1:0]   prod   [P];
  logic signed [PW-1:0]   res    [P];
  logic [IW-1:0]          a_idx  [P];
  logic [KW-1:0]          y_idx  [P];

  logic last_a, last_x, col_last, grp_last, k_last;

  assign last_a   = (idx == IW'(M * N - 1));
  assign last_x   = (idx == IW'(N - 1));
  assign col_last = (col == CW'(N - 1));
  assign grp_last = (grp == GW'(G - 1));
  assign k_last   = (k == KW'(M - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (load_matrix)      state_nx = LOAD_A;
        else if (load_vector) state_nx = LOAD_X;
        else if (start)       state_nx = COMPUTE;
      end
      LOAD_A:  if (in_valid && last_a) state_nx = IDLE;
      LOAD_X:  if (in_valid && last_x) state_nx = IDLE;
      COMPUTE: if (col_last && grp_last) state_nx = DRAIN;
      DRAIN:   if (out_ready && k_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD_A) || (state == LOAD_X);
    out_valid = (state == DRAIN);
    busy      = (state != IDLE);
    data_out  = (state == DRAIN) ? y_mem[k] : '0;
  end

  // Lane p works on row grp*P+p; the accumulator restarts on column 0 of every group.
  always_comb begin
    for (int p = 0; p < P; p++) begin
      a_idx[p]  = IW'((int'(grp) * P + p) * N + int'(col));
      y_idx[p]  = KW'(int'(grp) * P + p);
      prod[p]   = PW'(a_mem[a_idx[p]]) * PW'(x_mem[col]);
      acc_nx[p] = ((col == '0) ? '0 : acc[p]) + ACCW'(prod[p]);
      if (SAT != 0) begin
        if (acc_nx[p] > MAXV)      res[p] = MAXV[PW-1:0];
        else if (acc_nx[p] < MINV) res[p] = MINV[PW-1:0];
        else                       res[p] = acc_nx[p][PW-1:0];
      end else begin
        res[p] = acc_nx[p][PW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx  <= '0;
      col  <= '0;
      grp  <= '0;
      k    <= '0;
      done <= 1'b0;
      for (int p = 0; p < P; p++) acc[p] <= '0;
    end else begin
      done <= (state == DRAIN) && out_ready && k_last;
      if (in_ready && in_valid) idx <= idx + 1'b1;
      else if (state == IDLE)   idx <= '0;
      if (state == COMPUTE) begin
        col <= col_last ? '0 : col + 1'b1;
        if (col_last) grp <= grp_last ? '0 : grp + 1'b1;
        for (int p = 0; p < P; p++) acc[p] <= acc_nx[p];
      end else begin
        col <= '0;
        grp <= '0;
      end
      if (state == DRAIN) begin
        if (out_ready) k <= k_last ? '0 : k + 1'b1;
      end else begin
        k <= '0;
      end
    end
  end

  // Storage is never cleared so A and x survive reset and can be reused by later starts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == LOAD_A && in_valid) a_mem[idx] <= data_in;
      if (state == LOAD_X && in_valid) x_mem[idx[CW-1:0]] <= data_in;
      if (state == COMPUTE && col_last)
        for (int p = 0; p < P; p++) y_mem[y_idx[p]] <= res[p];
    end
  end

endmodule

// File: tb/tb_mvm_stream_par.sv
`timescale 1ns/1ps
// Directed bench for mvm_stream_par: five instances (P=2 wrap, P=2 saturate, P=1/4/8 wrap) share one input bus.

module tb_mvm_stream_par;
  localparam int NI = 5;
  localparam int PV [NI] = '{2, 2, 1, 4, 8};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, load_matrix = 1'b0, load_vector = 1'b0, start = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1, aux_en = 1'b1, or_toggle = 1'b0;
  logic signed [7:0] data_in = '0;
  logic lm_a, lv_a, st_a;
  assign lm_a = load_matrix & aux_en;
  assign lv_a = load_vector & aux_en;
  assign st_a = start & aux_en;

  logic [NI-1:0] ov, bz, dn, ir;
  logic signed [15:0] od [NI];

  mvm_stream_par #(.M(8), .N(8), .B(8), .P(2), .SAT(0)) u_main (.clk(clk), .reset(reset),
    .load_matrix(load_matrix), .load_vector(load_vector), .start(start), .in_valid(in_valid),
    .in_ready(ir[0]), .data_in(data_in), .out_valid(ov[0]), .out_ready(out_ready),
    .data_out(od[0]), .busy(bz[0]), .done(dn[0]));
  mvm_stream_par #(.M(8), .N(8), .B(8), .P(2), .SAT(1)) u_sat (.clk(clk), .reset(reset),
    .load_matrix(lm_a), .load_vector(lv_a), .start(st_a), .in_valid(in_valid),
    .in_ready(ir[1]), .data_in(data_in), .out_valid(ov[1]), .out_ready(out_ready),
    .data_out(od[1]), .busy(bz[1]), .done(dn[1]));
  mvm_stream_par #(.M(8), .N(8), .B(8), .P(1), .SAT(0)) u_p1 (.clk(clk), .reset(reset),
    .load_matrix(lm_a), .load_vector(lv_a), .start(st_a), .in_valid(in_valid),
    .in_ready(ir[2]), .data_in(data_in), .out_valid(ov[2]), .out_ready(out_ready),
    .data_out(od[2]), .busy(bz[2]), .done(dn[2]));
  mvm_stream_par #(.M(8), .N(8), .B(8), .P(4), .SAT(0)) u_p4 (.clk(clk), .reset(reset),
    .load_matrix(lm_a), .load_vector(lv_a), .start(st_a), .in_valid(in_valid),
    .in_ready(ir[3]), .data_in(data_in), .out_valid(ov[3]), .out_ready(out_ready),
    .data_out(od[3]), .busy(bz[3]), .done(dn[3]));
  mvm_stream_par #(.M(8), .N(8), .B(8), .P(8), .SAT(0)) u_p8 (.clk(clk), .reset(reset),
    .load_matrix(lm_a), .load_vector(lv_a), .start(st_a), .in_valid(in_valid),
    .in_ready(ir[4]), .data_in(data_in), .out_valid(ov[4]), .out_ready(out_ready),
    .data_out(od[4]), .busy(bz[4]), .done(dn[4]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = or_toggle ? ~out_ready : 1'b1;
  end

  int total = 0, bad = 0;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Output monitor: collects accepted words, first-valid cycle, done pulses, stall stability.
  int q [NI][$];
  int rise [NI] = '{default: 0};
  int dcnt [NI] = '{default: 0};
  int dlast [NI] = '{default: 0};
  logic [NI-1:0] prev_ov = '0, prev_stall = '0;
  logic signed [15:0] prev_dat [NI];
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (ov[i] && prev_stall[i]) chk($sformatf("stable_u%0d", i), od[i], prev_dat[i]);
      if (ov[i] && !prev_ov[i]) rise[i] = cyc;
      if (ov[i] && out_ready) q[i].push_back(int'(od[i]));
      if (dn[i]) begin
        dcnt[i]++;
        dlast[i] = cyc;
      end
      prev_stall[i] = ov[i] & ~out_ready;
      prev_ov[i]    = ov[i];
      prev_dat[i]   = od[i];
    end
  end

  logic signed [7:0] am [64];
  logic signed [7:0] xv [8];
  int e0 [8], e1 [8];
  int st_cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic lm, input logic lv, input logic st);
    load_matrix = lm; load_vector = lv; start = st;
    tick();
    load_matrix = 1'b0; load_vector = 1'b0; start = 1'b0;
  endtask

  task automatic feed(input bit is_a, input bit gaps);
    int n;
    n = is_a ? 64 : 8;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
      end
      in_valid = 1'b1;
      data_in  = is_a ? am[i] : xv[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic golden();
    int s;
    logic [15:0] t;
    for (int r = 0; r < 8; r++) begin
      s = 0;
      for (int c = 0; c < 8; c++) s += int'(am[r*8+c]) * int'(xv[c]);
      e1[r] = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
      t = s[15:0];
      e0[r] = int'($signed(t));
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (bz != '0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_timeout"}, int'(bz == '0), 1);
    tick();
  endtask

  task automatic run_check(input string nm);
    int base [NI];
    int db [NI];
    for (int i = 0; i < NI; i++) begin
      base[i] = q[i].size();
      db[i]   = dcnt[i];
    end
    st_cyc = cyc;
    pulse(1'b0, 1'b0, 1'b1);
    wait_idle(nm);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_cnt_u%0d", nm, i), q[i].size() - base[i], 8);
      chk($sformatf("%s_done_u%0d", nm, i), dcnt[i] - db[i], 1);
      for (int j = 0; j < 8; j++)
        if (q[i].size() > base[i] + j)
          chk($sformatf("%s_y%0d_u%0d", nm, j, i), q[i][base[i]+j], (i == 1) ? e1[j] : e0[j]);
    end
  endtask

  typedef struct {
    int akind;  // 0 constant, 1 identity, 2 row0=+127 rest constant
    int aval;
    int xkind;  // 0 constant, 1 ramp 1..8
    int xval;
    bit lda;
    bit ldx;
    int y0 [8];
    int y1 [8];
  } vec_t;

  vec_t tv [6];

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{1, 0, 1, 0, 1'b1, 1'b1, '{1, 2, 3, 4, 5, 6, 7, 8}, '{1, 2, 3, 4, 5, 6, 7, 8}};
    tv[1] = '{0, 1, 0, 1, 1'b1, 1'b1, '{default: 8}, '{default: 8}};
    tv[2] = '{0, 1, 0, 1, 1'b0, 1'b0, '{default: 8}, '{default: 8}};
    tv[3] = '{0, 1, 0, 2, 1'b0, 1'b1, '{default: 16}, '{default: 16}};
    tv[4] = '{0, -128, 0, -128, 1'b1, 1'b1, '{default: 0}, '{default: 32767}};
    tv[5] = '{2, -128, 0, -128, 1'b1, 1'b0, '{1024, 0, 0, 0, 0, 0, 0, 0},
              '{-32768, 32767, 32767, 32767, 32767, 32767, 32767, 32767}};

    repeat (3) tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_busy", bz, 0);
    chk("rst_out_valid", ov, 0);
    chk("rst_in_ready", ir, 0);
    chk("rst_done", dn, 0);
    chk("rst_data_out", od[0], 0);
    tick();

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 64; i++) begin
        case (tv[v].akind)
          1:       am[i] = (i / 8 == i % 8) ? 8'sd1 : 8'sd0;
          2:       am[i] = (i / 8 == 0) ? 8'sd127 : 8'(tv[v].aval);
          default: am[i] = 8'(tv[v].aval);
        endcase
      end
      for (int c = 0; c < 8; c++) xv[c] = (tv[v].xkind == 1) ? 8'(c + 1) : 8'(tv[v].xval);
      if (tv[v].lda) begin pulse(1'b1, 1'b0, 1'b0); feed(1'b1, 1'b0); end
      if (tv[v].ldx) begin pulse(1'b0, 1'b1, 1'b0); feed(1'b0, 1'b0); end
      e0 = tv[v].y0;
      e1 = tv[v].y1;
      run_check($sformatf("v%0d", v));
      if (v == 0)
        for (int i = 0; i < NI; i++) begin
          chk($sformatf("lat_u%0d", i), rise[i] - st_cyc, 1 + 64 / PV[i]);
          chk($sformatf("done_lat_u%0d", i), dlast[i] - rise[i], 8);
        end
    end

    // Random data, gapped loads, alternating out_ready.
    for (int i = 0; i < 64; i++) am[i] = 8'($urandom_range(0, 255));
    for (int c = 0; c < 8; c++) xv[c] = 8'($urandom_range(0, 255));
    golden();
    or_toggle = 1'b1;
    pulse(1'b1, 1'b0, 1'b0); feed(1'b1, 1'b1);
    pulse(1'b0, 1'b1, 1'b0); feed(1'b0, 1'b1);
    run_check("bp");
    or_toggle = 1'b0;
    tick();

    // Reset three cycles into COMPUTE, then rerun on the retained A/x.
    begin
      int d0;
      d0 = dcnt[0] + dcnt[1] + dcnt[2] + dcnt[3] + dcnt[4];
      pulse(1'b0, 1'b0, 1'b1);
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_busy", bz, 0);
      chk("midrst_out_valid", ov, 0);
      repeat (80) tick();
      chk("midrst_no_done", dcnt[0] + dcnt[1] + dcnt[2] + dcnt[3] + dcnt[4] - d0, 0);
    end
    run_check("rerun");

    // Commands during COMPUTE and DRAIN on the main instance only.
    begin
      int base, db, n;
      aux_en = 1'b0;
      base = q[0].size();
      db = dcnt[0];
      pulse(1'b0, 1'b0, 1'b1);
      repeat (5) tick();
      pulse(1'b0, 1'b1, 1'b0);
      n = 0;
      while (!ov[0] && n < 200) begin tick(); n++; end
      chk("ign_reach_drain", int'(ov[0]), 1);
      pulse(1'b0, 1'b0, 1'b1);
      wait_idle("ign");
      repeat (3) tick();
      chk("ign_idle", int'(bz[0]), 0);
      chk("ign_cnt", q[0].size() - base, 8);
      chk("ign_done", dcnt[0] - db, 1);
      for (int j = 0; j < 8; j++)
        if (q[0].size() > base + j) chk($sformatf("ign_y%0d", j), q[0][base+j], e0[j]);
      aux_en = 1'b1;
    end

    // load_matrix and start together: the load wins, no compute follows.
    for (int i = 0; i < 64; i++) am[i] = (i / 8 == i % 8) ? 8'sd1 : 8'sd0;
    pulse(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("ls_in_ready", ir, 5'h1f);
    tick();
    feed(1'b1, 1'b0);
    repeat (2) tick();
    chk("ls_idle", bz, 0);
    golden();
    run_check("ls");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
